id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 270 +++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Instruction decode stage: register file with write-through bypass,
// branch/jump resolution, load-use hazard detection and the ID/EX register.
// Ports: i_clk/i_reset (async, active-low), i_enable (step/run)
//   i_instruction/i_pc from IF; i_wb_* write-back; i_ex_mem_read/i_ex_rt hazard
//   o_stall/o_pc_src/o_target combinational feedback to IF
//   o_* registered ID/EX bundle (data fields, decoded controls, o_halt)
module id_stage #(
  parameter int NB_INST = 32,
  parameter int NB_ADDR = 32,
  parameter int NB_REG  = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [NB_INST-1:0] i_instruction,
  input  logic [NB_ADDR-1:0] i_pc,
  input  logic               i_wb_write,
  input  logic [NB_REG-1:0]  i_wb_addr,
  input  logic [NB_INST-1:0] i_wb_data,
  input  logic               i_ex_mem_read,
  input  logic [NB_REG-1:0]  i_ex_rt,
  output logic               o_stall,
  output logic               o_pc_src,
  output logic [NB_ADDR-1:0] o_target,
  output logic [NB_INST-1:0] o_rs_data,
  output logic [NB_INST-1:0] o_rt_data,
  output logic [NB_INST-1:0] o_imm,
  output logic [NB_ADDR-1:0] o_pc,
  output logic [NB_REG-1:0]  o_rs,
  output logic [NB_REG-1:0]  o_rt,
  output logic [NB_REG-1:0]  o_rd,
  output logic [NB_REG-1:0]  o_shamt,
  output logic [5:0]         o_opcode,
  output logic [5:0]         o_funct,
  output logic               o_reg_write,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_mem_to_reg,
  output logic               o_alu_src,
  output logic               o_mem_unsigned,
  output logic               o_halt,
  output logic [1:0]         o_reg_dst,
  output logic [1:0]         o_mem_size
);

  localparam int DEPTH = 2**NB_REG;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_XOR   = 6'h26;

  typedef struct packed {
    logic [NB_INST-1:0] rs_data;
    logic [NB_INST-1:0] rt_data;
    logic [NB_INST-1:0] imm;
    logic [NB_ADDR-1:0] pc;
    logic [NB_REG-1:0]  rs;
    logic [NB_REG-1:0]  rt;
    logic [NB_REG-1:0]  rd;
    logic [NB_REG-1:0]  shamt;
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               alu_src;
    logic               mem_unsigned;
    logic               halt;
    logic [1:0]         reg_dst;
    logic [1:0]         mem_size;
  } id_ex_t;

  logic [NB_INST-1:0] rf [DEPTH];
  logic [NB_REG-1:0]  rs, rt;
  logic [5:0]         op, fn;
  logic [NB_INST-1:0] rs_val, rt_val, sx;
  logic [NB_ADDR-1:0] br_off;
  logic               we;
  logic               is_halt, is_r, is_ld, is_st;
  logic               valid, use_rs, use_rt;
  logic               beq, bne, jmp, jreg;
  logic               hazard, taken, live;
  logic [1:0]         size;
  id_ex_t             d, q;

  assign op = i_instruction[31:26];
  assign fn = i_instruction[5:0];
  assign rs = i_instruction[21 +: NB_REG];
  assign rt = i_instruction[16 +: NB_REG];
  assign sx = {{(NB_INST-16){i_instruction[15]}},
               i_instruction[15:0]};
  assign br_off = {{(NB_ADDR-16){i_instruction[15]}},
                   i_instruction[15:0]};

  assign is_halt = (i_instruction == '0);
  assign is_r    = (op == OP_R) && !is_halt;
  assign is_ld   = op inside {6'h20, 6'h21, 6'h23,
                              6'h24, 6'h25, 6'h27};
  assign is_st   = op inside {6'h28, 6'h29, 6'h2B};
  // op[1:0]: 00 byte, 01 half, 11 word
  assign size    = (op[1:0] == 2'b00) ? 2'd0 :
                   (op[1:0] == 2'b01) ? 2'd1 : 2'd2;

  assign we = i_enable && i_wb_write && (i_wb_addr != '0);

  assign rs_val = (rs == '0) ? '0 :
                  (we && i_wb_addr == rs) ? i_wb_data : rf[rs];
  assign rt_val = (rt == '0) ? '0 :
                  (we && i_wb_addr == rt) ? i_wb_data : rf[rt];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < DEPTH; k++) rf[k] <= '0;
    end else if (we) begin
      rf[i_wb_addr] <= i_wb_data;
    end
  end

  always_comb begin
    d         = '0;
    valid     = 1'b0;
    use_rs    = 1'b0;
    use_rt    = 1'b0;
    beq       = 1'b0;
    bne       = 1'b0;
    jmp       = 1'b0;
    jreg      = 1'b0;
    d.rs_data = rs_val;
    d.rt_data = rt_val;
    d.pc      = i_pc;
    d.rs      = rs;
    d.rt      = rt;
    d.rd      = i_instruction[11 +: NB_REG];
    d.shamt   = i_instruction[6 +: NB_REG];
    d.opcode  = op;
    d.funct   = fn;
    unique case (1'b1)
      is_halt: begin
        valid  = 1'b1;
        d.halt = 1'b1;
      end
      is_r: begin
        unique case (fn)
          F_ADDU, F_XOR, F_SLL, F_JALR: begin
            valid       = 1'b1;
            use_rs      = (fn != F_SLL);
            use_rt      = 1'b1;
            jreg        = (fn == F_JALR);
            d.reg_write = 1'b1;
            d.reg_dst   = 2'd1;
          end
          F_JR: begin
            valid  = 1'b1;
            use_rs = 1'b1;
            use_rt = 1'b1;
            jreg   = 1'b1;
          end
          default: ;
        endcase
      end
      is_ld: begin
        valid          = 1'b1;
        use_rs         = 1'b1;
        d.mem_read     = 1'b1;
        d.mem_to_reg   = 1'b1;
        d.reg_write    = 1'b1;
        d.alu_src      = 1'b1;
        d.mem_unsigned = op[2];
        d.mem_size     = size;
        d.imm          = sx;
      end
      is_st: begin
        valid       = 1'b1;
        use_rs      = 1'b1;
        use_rt      = 1'b1;
        d.mem_write = 1'b1;
        d.alu_src   = 1'b1;
        d.mem_size  = size;
        d.imm       = sx;
      end
      (op == OP_ADDI): begin
        valid       = 1'b1;
        use_rs      = 1'b1;
        d.reg_write = 1'b1;
        d.alu_src   = 1'b1;
        d.imm       = sx;
      end
      (op == OP_LUI): begin
        valid       = 1'b1;
        d.reg_write = 1'b1;
        d.alu_src   = 1'b1;
        d.imm       = {i_instruction[15:0],
                       {(NB_INST-16){1'b0}}};
      end
      (op == OP_BEQ || op == OP_BNE): begin
        valid  = 1'b1;
        use_rs = 1'b1;
        use_rt = 1'b1;
        beq    = (op == OP_BEQ);
        bne    = (op == OP_BNE);
        d.imm  = sx;
      end
      (op == OP_J || op == OP_JAL): begin
        valid       = 1'b1;
        jmp         = 1'b1;
        d.reg_write = (op == OP_JAL);
        d.reg_dst   = (op == OP_JAL) ? 2'd2 : 2'd0;
      end
      default: ;
    endcase
  end

  assign hazard = i_ex_mem_read && (i_ex_rt != '0) &&
                  ((use_rs && i_ex_rt == rs) ||
                   (use_rt && i_ex_rt == rt));
  assign taken  = jmp || jreg ||
                  (beq && rs_val == rt_val) ||
                  (bne && rs_val != rt_val);
  // feedback is forced low during reset and while paused
  assign live     = i_reset && i_enable;
  assign o_stall  = live && hazard;
  assign o_pc_src = live && !hazard && taken;

  always_comb begin
    o_target = i_pc + br_off;
    if (jreg)
      o_target = NB_ADDR'(rs_val);
    else if (jmp)
      o_target = {i_pc[NB_ADDR-1:26], i_instruction[25:0]};
    if (!i_reset) o_target = '0;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)
      q <= '0;
    else if (i_enable)
      q <= (valid && !hazard) ? d : '0;
  end

  assign o_rs_data      = q.rs_data;
  assign o_rt_data      = q.rt_data;
  assign o_imm          = q.imm;
  assign o_pc           = q.pc;
  assign o_rs           = q.rs;
  assign o_rt           = q.rt;
  assign o_rd           = q.rd;
  assign o_shamt        = q.shamt;
  assign o_opcode       = q.opcode;
  assign o_funct        = q.funct;
  assign o_reg_write    = q.reg_write;
  assign o_mem_read     = q.mem_read;
  assign o_mem_write    = q.mem_write;
  assign o_mem_to_reg   = q.mem_to_reg;
  assign o_alu_src      = q.alu_src;
  assign o_mem_unsigned = q.mem_unsigned;
  assign o_halt         = q.halt;
  assign o_reg_dst      = q.reg_dst;
  assign o_mem_size     = q.mem_size;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed table, hand sequences,
// and randomized stimulus against a mnemonic-level reference model.
module tb_id_stage;

  logic        i_clk = 1'b0;
  logic        i_reset, i_enable;
  logic [31:0] i_instruction, i_pc;
  logic        i_wb_write;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        i_ex_mem_read;
  logic [4:0]  i_ex_rt;
  logic        o_stall, o_pc_src;
  logic [31:0] o_target, o_rs_data, o_rt_data, o_imm, o_pc;
  logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
  logic [5:0]  o_opcode, o_funct;
  logic        o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg;
  logic        o_alu_src, o_mem_unsigned, o_halt;
  logic [1:0]  o_reg_dst, o_mem_size;

  id_stage dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable),
    .i_instruction(i_instruction), .i_pc(i_pc),
    .i_wb_write(i_wb_write), .i_wb_addr(i_wb_addr),
    .i_wb_data(i_wb_data),
    .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt),
    .o_stall(o_stall), .o_pc_src(o_pc_src), .o_target(o_target),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm(o_imm),
    .o_pc(o_pc), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
    .o_shamt(o_shamt), .o_opcode(o_opcode), .o_funct(o_funct),
    .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg),
    .o_alu_src(o_alu_src), .o_mem_unsigned(o_mem_unsigned),
    .o_halt(o_halt), .o_reg_dst(o_reg_dst), .o_mem_size(o_mem_size)
  );

  always #5 i_clk = ~i_clk;

  typedef enum {
    M_ADDU, M_XOR, M_SLL, M_JR, M_JALR,
    M_LB, M_LH, M_LW, M_LBU, M_LHU, M_LWU,
    M_SB, M_SH, M_SW, M_ADDI, M_LUI,
    M_BEQ, M_BNE, M_J, M_JAL, M_HALT, M_BAD
  } mn_t;

  typedef struct packed {
    logic        stall, pc_src;
    logic [31:0] target, rs_data, rt_data, imm, pc;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  opcode, funct;
    logic        reg_write, mem_read, mem_write, mem_to_reg;
    logic        alu_src, mem_unsigned, halt;
    logic [1:0]  reg_dst, mem_size;
  } exp_t;

  typedef struct {
    logic [31:0] instr, pc;
    logic        exmr;
    logic [4:0]  exrt;
    logic        stall, pc_src;
    logic [31:0] target;
    logic        rw;
    logic [1:0]  rdst;
    logic        alusrc;
    logic [31:0] imm, rsd, rtd;
  } vec_t;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] rf_m [32];
  exp_t        exp_q;
  logic        fb_stall, fb_pc_src;
  logic [31:0] fb_target;
  vec_t        tbl [$];

  localparam logic [31:0] BAD = 32'hFC00_0000;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn,
      input logic [4:0] rs, rt, rd, sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op,
      input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op,
      input logic [25:0] idx);
    return {op, idx};
  endfunction

  function automatic mn_t classify(input logic [31:0] w);
    if (w == 32'h0) return M_HALT;
    case (w[31:26])
      6'h00: case (w[5:0])
        6'h21: return M_ADDU;
        6'h26: return M_XOR;
        6'h00: return M_SLL;
        6'h08: return M_JR;
        6'h09: return M_JALR;
        default: return M_BAD;
      endcase
      6'h20: return M_LB;
      6'h21: return M_LH;
      6'h23: return M_LW;
      6'h24: return M_LBU;
      6'h25: return M_LHU;
      6'h27: return M_LWU;
      6'h28: return M_SB;
      6'h29: return M_SH;
      6'h2B: return M_SW;
      6'h08: return M_ADDI;
      6'h0F: return M_LUI;
      6'h04: return M_BEQ;
      6'h05: return M_BNE;
      6'h02: return M_J;
      6'h03: return M_JAL;
      default: return M_BAD;
    endcase
  endfunction

  function automatic logic [31:0] rdv(input logic [4:0] a,
      input logic en, wbw, input logic [4:0] wba,
      input logic [31:0] wbd);
    if (a == 0) return 32'h0;
    if (en && wbw && wba == a) return wbd;
    return rf_m[a];
  endfunction

  function automatic exp_t model(input logic [31:0] w, pc,
      input logic en, exmr, input logic [4:0] exrt,
      input logic wbw, input logic [4:0] wba, input logic [31:0] wbd);
    exp_t e;
    mn_t m;
    logic [4:0] rs, rt;
    logic [31:0] rsv, rtv, sx;
    logic ld, st, rr, urs, urt, tk;
    e = '0;
    m = classify(w);
    rs = w[25:21];
    rt = w[20:16];
    rsv = rdv(rs, en, wbw, wba, wbd);
    rtv = rdv(rt, en, wbw, wba, wbd);
    sx = {{16{w[15]}}, w[15:0]};
    ld = m inside {M_LB, M_LH, M_LW, M_LBU, M_LHU, M_LWU};
    st = m inside {M_SB, M_SH, M_SW};
    rr = m inside {M_ADDU, M_XOR, M_SLL, M_JR, M_JALR};
    urs = !(m inside {M_LUI, M_J, M_JAL, M_HALT, M_SLL, M_BAD});
    urt = rr || st || m inside {M_BEQ, M_BNE};
    e.stall = en && exmr && exrt != 0 &&
              ((urs && exrt == rs) || (urt && exrt == rt));
    tk = m inside {M_J, M_JAL, M_JR, M_JALR} ||
         (m == M_BEQ && rsv == rtv) || (m == M_BNE && rsv != rtv);
    e.pc_src = en && !e.stall && tk;
    if (m inside {M_BEQ, M_BNE}) e.target = pc + sx;
    else if (m inside {M_J, M_JAL}) e.target = {pc[31:26], w[25:0]};
    else e.target = rsv;
    if (e.stall || m == M_BAD) return e;
    e.halt = (m == M_HALT);
    e.rs_data = rsv;
    e.rt_data = rtv;
    e.pc = pc;
    e.rs = rs;
    e.rt = rt;
    e.rd = w[15:11];
    e.shamt = w[10:6];
    e.opcode = w[31:26];
    e.funct = w[5:0];
    if (ld || st || m inside {M_ADDI, M_BEQ, M_BNE}) e.imm = sx;
    if (m == M_LUI) e.imm = {w[15:0], 16'h0};
    e.mem_read = ld;
    e.mem_to_reg = ld;
    e.mem_write = st;
    e.mem_unsigned = m inside {M_LBU, M_LHU, M_LWU};
    e.alu_src = ld || st || m inside {M_ADDI, M_LUI};
    e.reg_write = ld || m inside {M_ADDI, M_LUI, M_ADDU, M_XOR,
                                  M_SLL, M_JALR, M_JAL};
    if (m inside {M_ADDU, M_XOR, M_SLL, M_JALR}) e.reg_dst = 2'd1;
    if (m == M_JAL) e.reg_dst = 2'd2;
    if (m inside {M_LH, M_LHU, M_SH}) e.mem_size = 2'd1;
    if (m inside {M_LW, M_LWU, M_SW}) e.mem_size = 2'd2;
    return e;
  endfunction

  task automatic check_regs();
    chk("reg_write", o_reg_write, exp_q.reg_write);
    chk("mem_read", o_mem_read, exp_q.mem_read);
    chk("mem_write", o_mem_write, exp_q.mem_write);
    chk("mem_to_reg", o_mem_to_reg, exp_q.mem_to_reg);
    chk("alu_src", o_alu_src, exp_q.alu_src);
    chk("mem_unsigned", o_mem_unsigned, exp_q.mem_unsigned);
    chk("halt", o_halt, exp_q.halt);
    if (exp_q.reg_write) chk("reg_dst", o_reg_dst, exp_q.reg_dst);
    if (exp_q.mem_read || exp_q.mem_write)
      chk("mem_size", o_mem_size, exp_q.mem_size);
    if (!exp_q.halt) begin
      chk("rs_data", o_rs_data, exp_q.rs_data);
      chk("rt_data", o_rt_data, exp_q.rt_data);
      chk("imm", o_imm, exp_q.imm);
      chk("pc", o_pc, exp_q.pc);
      chk("rs", o_rs, exp_q.rs);
      chk("rt", o_rt, exp_q.rt);
      chk("rd", o_rd, exp_q.rd);
      chk("shamt", o_shamt, exp_q.shamt);
      chk("opcode", o_opcode, exp_q.opcode);
      chk("funct", o_funct, exp_q.funct);
    end
  endtask

  task automatic step(input logic [31:0] w, pc, input logic en,
      input logic exmr, input logic [4:0] exrt, input logic wbw,
      input logic [4:0] wba, input logic [31:0] wbd);
    exp_t e;
    i_instruction = w;
    i_pc = pc;
    i_enable = en;
    i_ex_mem_read = exmr;
    i_ex_rt = exrt;
    i_wb_write = wbw;
    i_wb_addr = wba;
    i_wb_data = wbd;
    #1;
    e = model(w, pc, en, exmr, exrt, wbw, wba, wbd);
    fb_stall = o_stall;
    fb_pc_src = o_pc_src;
    fb_target = o_target;
    chk("stall", o_stall, e.stall);
    chk("pc_src", o_pc_src, e.pc_src);
    if (e.pc_src) chk("target", o_target, e.target);
    @(posedge i_clk);
    #1;
    if (en) begin
      exp_q = e;
      if (wbw && wba != 0) rf_m[wba] = wbd;
    end
    check_regs();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    step(BAD, 32'h0, 1'b1, 1'b0, 5'd0, 1'b1, a, v);
  endtask

  task automatic clear_model();
    for (int k = 0; k < 32; k++) rf_m[k] = 32'h0;
    exp_q = '0;
  endtask

  function automatic logic [31:0] gen();
    logic [4:0] rs, rt, rd, sh;
    logic [15:0] im;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 31));
    sh = 5'($urandom_range(0, 31));
    im = 16'($urandom);
    case ($urandom_range(0, 21))
      0: return enc_r(6'h21, rs, rt, rd, sh);
      1: return enc_r(6'h26, rs, rt, rd, sh);
      2: return enc_r(6'h00, 5'd0, rt, rd, sh);
      3: return enc_r(6'h08, rs, 5'd0, 5'd0, 5'd0);
      4: return enc_r(6'h09, rs, 5'd0, rd, 5'd0);
      5: return enc_i(6'h20, rs, rt, im);
      6: return enc_i(6'h21, rs, rt, im);
      7: return enc_i(6'h23, rs, rt, im);
      8: return enc_i(6'h24, rs, rt, im);
      9: return enc_i(6'h25, rs, rt, im);
      10: return enc_i(6'h27, rs, rt, im);
      11: return enc_i(6'h28, rs, rt, im);
      12: return enc_i(6'h29, rs, rt, im);
      13: return enc_i(6'h2B, rs, rt, im);
      14: return enc_i(6'h08, rs, rt, im);
      15: return enc_i(6'h0F, 5'd0, rt, im);
      16: return enc_i(6'h04, rs, rt, im);
      17: return enc_i(6'h05, rs, rt, im);
      18: return enc_j(6'h02, 26'($urandom));
      19: return enc_j(6'h03, 26'($urandom));
      20: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // instr, pc, exmr, exrt, stall, pc_src, target,
    // rw, rdst, alusrc, imm, rs_data, rt_data
    // (r1=5, r2=7, r3=0, r4=0)
    tbl.push_back('{enc_r(6'h21, 1, 2, 6, 0), 32'd20, 0, 0,
                    0, 0, 0, 1, 1, 0, 0, 5, 7});
    tbl.push_back('{enc_i(6'h08, 3, 4, 16'h800F), 32'd24, 0, 0,
                    0, 0, 0, 1, 0, 1, 32'hFFFF800F, 0, 0});
    tbl.push_back('{enc_i(6'h04, 4, 4, 16'd255), 32'd10, 0, 0,
                    0, 1, 32'd265, 0, 0, 0, 32'd255, 0, 0});
    tbl.push_back('{enc_i(6'h05, 3, 4, 16'd5), 32'd10, 0, 0,
                    0, 0, 0, 0, 0, 0, 32'd5, 0, 0});
    tbl.push_back('{enc_r(6'h26, 2, 1, 5, 0), 32'd30, 1, 2,
                    1, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{enc_r(6'h26, 2, 1, 5, 0), 32'd30, 1, 0,
                    0, 0, 0, 1, 1, 0, 0, 7, 5});
    tbl.push_back('{enc_i(6'h23, 1, 2, 16'd4), 32'd31, 1, 2,
                    0, 0, 0, 1, 0, 1, 32'd4, 5, 7});
    tbl.push_back('{enc_i(6'h2B, 1, 2, 16'hFFFC), 32'd32, 1, 2,
                    1, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{enc_j(6'h02, 26'h100), 32'hFC00_0010, 0, 0,
                    0, 1, 32'hFC00_0100, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{enc_j(6'h03, 26'h3FF_FFFF), 32'h0, 0, 0,
                    0, 1, 32'h03FF_FFFF, 1, 2, 0, 0, 0, 0});
    tbl.push_back('{enc_r(6'h08, 1, 0, 0, 0), 32'd40, 0, 0,
                    0, 1, 32'd5, 0, 0, 0, 0, 5, 0});
    tbl.push_back('{enc_i(6'h0F, 0, 7, 16'h1234), 32'd41, 0, 0,
                    0, 0, 0, 1, 0, 1, 32'h1234_0000, 0, 0});
    tbl.push_back('{BAD, 32'd42, 0, 0,
                    0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{enc_i(6'h05, 1, 2, 16'hFFFE), 32'd100, 0, 0,
                    0, 1, 32'd98, 0, 0, 0, 32'hFFFF_FFFE, 5, 7});
    tbl.push_back('{enc_i(6'h04, 1, 2, 16'd3), 32'd100, 0, 0,
                    0, 0, 0, 0, 0, 0, 32'd3, 5, 7});
    tbl.push_back('{enc_i(6'h04, 1, 1, 16'd3), 32'd100, 1, 1,
                    1, 0, 0, 0, 0, 0, 0, 0, 0});

    i_reset = 1'b1;
    i_enable = 1'b1;
    i_instruction = enc_i(6'h04, 0, 0, 16'd1);
    i_pc = 32'd7;
    i_wb_write = 1'b0;
    i_wb_addr = 5'd0;
    i_wb_data = 32'h0;
    i_ex_mem_read = 1'b0;
    i_ex_rt = 5'd0;
    clear_model();
    #1 i_reset = 1'b0;
    #1;
    chk("rst pc_src", o_pc_src, 1'b0);
    chk("rst target", o_target, 32'h0);
    chk("rst stall", o_stall, 1'b0);
    chk("rst halt", o_halt, 1'b0);
    chk("rst reg_write", o_reg_write, 1'b0);
    chk("rst pc", o_pc, 32'h0);
    @(posedge i_clk);
    @(posedge i_clk);
    #1 i_reset = 1'b1;

    wr(5'd1, 32'd5);
    wr(5'd2, 32'd7);
    wr(5'd3, 32'd0);
    wr(5'd4, 32'd0);

    foreach (tbl[k]) begin
      step(tbl[k].instr, tbl[k].pc, 1'b1, tbl[k].exmr, tbl[k].exrt,
           1'b0, 5'd0, 32'h0);
      chk($sformatf("tbl%0d stall", k), fb_stall, tbl[k].stall);
      chk($sformatf("tbl%0d pc_src", k), fb_pc_src, tbl[k].pc_src);
      if (tbl[k].pc_src)
        chk($sformatf("tbl%0d target", k), fb_target, tbl[k].target);
      chk($sformatf("tbl%0d rw", k), o_reg_write, tbl[k].rw);
      if (tbl[k].rw)
        chk($sformatf("tbl%0d rdst", k), o_reg_dst, tbl[k].rdst);
      chk($sformatf("tbl%0d alusrc", k), o_alu_src, tbl[k].alusrc);
      chk($sformatf("tbl%0d imm", k), o_imm, tbl[k].imm);
      chk($sformatf("tbl%0d rsd", k), o_rs_data, tbl[k].rsd);
      chk($sformatf("tbl%0d rtd", k), o_rt_data, tbl[k].rtd);
    end

    step(enc_r(6'h21, 1, 2, 6, 0), 32'd20, 1, 0, 0, 0, 0, 0);
    chk("addu rd", o_rd, 32'd6);

    // write-through and r0 hardwiring
    step(enc_r(6'h21, 3, 0, 8, 0), 32'd50, 1, 0, 0, 1, 3, 32'd40);
    chk("bypass rs", o_rs_data, 32'd40);
    step(enc_r(6'h21, 0, 3, 8, 0), 32'd51, 1, 0, 0, 1, 0, 32'd9);
    chk("r0 bypass", o_rs_data, 32'd0);
    chk("r3 stored", o_rt_data, 32'd40);
    step(enc_r(6'h21, 0, 0, 8, 0), 32'd52, 1, 0, 0, 0, 0, 0);
    chk("r0 read", o_rs_data, 32'd0);

    // halt lasts one slot
    step(32'h0, 32'd60, 1, 0, 0, 0, 0, 0);
    chk("halt set", o_halt, 1'b1);
    step(enc_r(6'h21, 1, 2, 6, 0), 32'd61, 1, 0, 0, 0, 0, 0);
    chk("halt clear", o_halt, 1'b0);

    // enable low: hold ID/EX, block writes and redirects
    step(enc_j(6'h02, 26'h55), 32'd70, 0, 0, 0, 1, 1, 32'd99);
    chk("hold pc_src", fb_pc_src, 1'b0);
    chk("hold rd", o_rd, 32'd6);
    chk("hold pc", o_pc, 32'd61);
    step(enc_r(6'h21, 1, 0, 9, 0), 32'd71, 1, 0, 0, 0, 0, 0);
    chk("no write paused", o_rs_data, 32'd5);

    // reset in the middle of a stall and a pending write
    i_instruction = enc_r(6'h26, 2, 1, 5, 0);
    i_enable = 1'b1;
    i_ex_mem_read = 1'b1;
    i_ex_rt = 5'd2;
    i_wb_write = 1'b1;
    i_wb_addr = 5'd5;
    i_wb_data = 32'd77;
    #3 i_reset = 1'b0;
    #1;
    chk("mid rst stall", o_stall, 1'b0);
    chk("mid rst reg_write", o_reg_write, 1'b0);
    chk("mid rst rs_data", o_rs_data, 32'h0);
    chk("mid rst rd", o_rd, 32'h0);
    @(posedge i_clk);
    @(posedge i_clk);
    #1 i_reset = 1'b1;
    clear_model();
    step(enc_r(6'h21, 1, 5, 8, 0), 32'd80, 1, 0, 0, 0, 0, 0);
    chk("post rst r1", o_rs_data, 32'h0);
    chk("post rst r5", o_rt_data, 32'h0);
    chk("post rst decode", o_reg_write, 1'b1);

    for (int k = 1; k < 8; k++) wr(5'(k), $urandom);
    for (int n = 0; n < 400; n++) begin
      step(gen(), $urandom, ($urandom_range(0, 7) != 0),
           1'($urandom), 5'($urandom_range(0, 7)),
           1'($urandom), 5'($urandom_range(0, 7)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
